// File: rtl/layer_pkg.sv
// ============================================================================
// Module  : layer_pkg
// Brief   : Shared convolution-layer types, default geometry and saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

package layer_pkg;

    localparam int DW     = 16;
    localparam int IN_CH  = 3;
    localparam int OUT_CH = 8;
    localparam int TAPS   = 9;

    typedef logic signed [DW-1:0] data_t;

    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DW - 1));

    // Arithmetic shift (floor) followed by clamp to the signed DW range.
    function automatic data_t sat_dw(input logic signed [63:0] acc, input int shift);
        logic signed [63:0] r;
        r = acc >>> shift;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        return data_t'(r);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_array_mac_lane.sv
// ============================================================================
// Module  : mac_lane
// Brief   : One output channel: products, adder tree, accumulator, sat/ReLU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_lane #(
    parameter int DW         = layer_pkg::DW,
    parameter int IN_CH      = layer_pkg::IN_CH,
    parameter int ACC_W      = 40,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  first_i,
    input  logic                  relu_i,
    input  logic [IN_CH*DW-1:0]   in_data_i,
    input  logic [IN_CH*DW-1:0]   weight_i,
    output logic [DW-1:0]         result_o
);
    import layer_pkg::*;

    logic signed [2*DW-1:0]  prod_d [IN_CH];
    logic signed [2*DW-1:0]  prod_q [IN_CH];
    logic signed [ACC_W-1:0] sum_w;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [63:0]      acc_ext;
    data_t                   sat_w;

    // Sign-extend both operands to 2*DW; the low 2*DW bits are the exact signed product.
    always_comb begin
        for (int c = 0; c < IN_CH; c++) begin
            prod_d[c] = {{DW{in_data_i[c*DW+DW-1]}}, in_data_i[c*DW +: DW]}
                      * {{DW{weight_i[c*DW+DW-1]}},  weight_i[c*DW +: DW]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < IN_CH; c++) begin
                prod_q[c] <= '0;
            end
        end else if (load_i) begin
            prod_q <= prod_d;
        end
    end

    always_comb begin
        sum_w = '0;
        for (int c = 0; c < IN_CH; c++) begin
            sum_w = sum_w + ACC_W'(prod_q[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (step_i) begin
            acc_q <= first_i ? sum_w : acc_q + sum_w;
        end
    end

    assign acc_ext  = 64'(acc_q);
    assign sat_w    = sat_dw(acc_ext, FRAC_SHIFT);
    assign result_o = (relu_i && sat_w[DW-1]) ? '0 : sat_w;

endmodule

`default_nettype wire

// File: rtl/conv_mac_array.sv
// ============================================================================
// Module  : conv_mac_array
// Brief   : Pipelined OUT_CH x IN_CH MAC array accumulating over TAPS beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_mac_array #(
    parameter int DW         = layer_pkg::DW,
    parameter int IN_CH      = layer_pkg::IN_CH,
    parameter int OUT_CH     = layer_pkg::OUT_CH,
    parameter int TAPS       = layer_pkg::TAPS,
    parameter int ACC_W      = 40,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_CH*DW-1:0]         in_data,
    input  logic [OUT_CH*IN_CH*DW-1:0]  weight,
    input  logic                        relu_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_CH*DW-1:0]        out_data,
    output logic                        busy
);
    import layer_pkg::*;

    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic [TAP_W-1:0]      tap_cnt_q;
    logic [TAP_W-1:0]      tap_cnt_d;
    logic                  en;
    logic                  accept;
    logic                  tap_first;
    logic                  tap_last;
    logic                  beat_relu;
    logic                  win_relu_q;
    logic                  s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
    logic                  s2_valid_q, s2_last_q, s2_relu_q;
    logic                  out_valid_q;
    logic [OUT_CH*DW-1:0]  out_data_q;
    logic [OUT_CH*DW-1:0]  lane_res;

    // A held, unconsumed result freezes every stage.
    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en && !rst;
    assign accept    = in_valid && in_ready;
    assign tap_first = (tap_cnt_q == '0);
    assign tap_last  = (tap_cnt_q == TAP_W'(TAPS - 1));
    assign tap_cnt_d = tap_last ? '0 : tap_cnt_q + 1'b1;
    assign beat_relu = tap_first ? relu_en : win_relu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt_q   <= '0;
            win_relu_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_relu_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            s1_valid_q <= accept;
            if (accept) begin
                tap_cnt_q  <= tap_cnt_d;
                win_relu_q <= beat_relu;
                s1_first_q <= tap_first;
                s1_last_q  <= tap_last;
                s1_relu_q  <= beat_relu;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_relu_q  <= s1_relu_q;
            if (s2_valid_q && s2_last_q) begin
                out_data_q  <= lane_res;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    for (genvar o = 0; o < OUT_CH; o++) begin : g_lane
        mac_lane #(
            .DW         (DW),
            .IN_CH      (IN_CH),
            .ACC_W      (ACC_W),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load_i    (accept),
            .step_i    (en && s1_valid_q),
            .first_i   (s1_first_q),
            .relu_i    (s2_relu_q),
            .in_data_i (in_data),
            .weight_i  (weight[o*IN_CH*DW +: IN_CH*DW]),
            .result_o  (lane_res[o*DW +: DW])
        );
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (tap_cnt_q != '0) || s1_valid_q || s2_valid_q;

endmodule

`default_nettype wire
